vga_rx: RTL and testbench

Receive-side VGA timing decoder: consumes the sync/blank/RGB stream that the VGA controller drives (pixel clock = `clock`), recovers pixel coordinates and pushes each active pixel as an (x, y, rgb) write into a frame-buffer or checker through a valid/ready port. It sits at the far end of the VGA interface: in simulation it loops back the controller outputs for self-checking, and in capture designs it fills a video memory. A small FIFO absorbs write-side back-pressure.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_rx_fifo.sv | 74 +++++++
 rtl/vga_rx.sv | 184 ++++++++++++++++++
 tb/tb_vga_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA receive path: coordinate widths,
// decoder FSM states and the pixel record carried through the write FIFO.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int RGB_W        = 24;
    localparam int PIX_W        = X_W + Y_W + RGB_W;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VSYNC  = 2'd1,
        FRAME  = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [RGB_W-1:0] rgb;
    } pixel_t;

    function automatic logic [X_W-1:0] x_inc_sat(input logic [X_W-1:0] x);
        return (x == {X_W{1'b1}}) ? x : x + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] y_inc_sat(input logic [Y_W-1:0] y);
        return (y == {Y_W{1'b1}}) ? y : y + Y_W'(1);
    endfunction

endpackage

// File: rtl/vga_rx_fifo.sv
// Show-ahead pixel FIFO: dout always presents the oldest entry; a push into a
// full FIFO is only accepted when a pop happens in the same cycle.
module vga_rx_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PIX_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage next-state.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers; storage is cleared so the idle output reads zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_rx.sv
// VGA timing decoder: recovers (x, y) from sync/blank and queues active pixels.
// Define VGA_RX_STATS_EN to measure frame size and derive locked from it.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vga_hsync,
    input  logic             vga_vsync,
    input  logic             vga_blank_n,
    input  logic [7:0]       vga_r,
    input  logic [7:0]       vga_g,
    input  logic [7:0]       vga_b,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [X_W-1:0]   wr_x,
    output logic [Y_W-1:0]   wr_y,
    output logic [RGB_W-1:0] wr_data,
    output logic             frame_done,
    output logic             locked,
    output logic             overflow,
    output logic [X_W-1:0]   meas_w,
    output logic [Y_W-1:0]   meas_h
);

    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_ACTIVE);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_ACTIVE);

    logic             hs_s1_q, vs_s1_q, blank_s1_q, hs_p_q, vs_p_q;
    logic [RGB_W-1:0] rgb_s1_q;
    rx_state_e        state_q, state_d;
    logic [X_W-1:0]   x_q, x_d, pix_x_s;
    logic [Y_W-1:0]   y_q, y_d;
    logic             line_act_q, line_act_d, pix_act_s;
    logic             frame_done_q, frame_done_d, locked_q, locked_d;
    logic             overflow_q, overflow_d;
    logic             hs_fall_s, vs_fall_s, vs_rise_s;
    logic             push_s, pop_s, full_s, empty_s;
    pixel_t           pix_in_s, pix_out_s;
`ifdef VGA_RX_STATS_EN
    logic [X_W-1:0]   meas_w_q, meas_w_d;
    logic [Y_W-1:0]   meas_h_q, meas_h_d;
`endif

    assign hs_fall_s = hs_p_q & ~hs_s1_q;
    assign vs_fall_s = vs_p_q & ~vs_s1_q;
    assign vs_rise_s = ~vs_p_q & vs_s1_q;

    // Pixel capture stage: only active pixels inside the window are queued.
    always_comb begin
        pix_x_s   = blank_s1_q ? x_inc_sat(x_q) : x_q;
        pix_act_s = blank_s1_q | line_act_q;
        push_s    = (state_q == FRAME) && blank_s1_q
                    && ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
        pix_in_s  = '{x: x_q, y: y_q, rgb: rgb_s1_q};
    end

    // Frame FSM; a line close is folded in before a same-cycle frame close.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        line_act_d   = line_act_q;
        frame_done_d = 1'b0;
        locked_d     = locked_q;
        overflow_d   = overflow_q | (push_s & full_s & ~pop_s);
`ifdef VGA_RX_STATS_EN
        meas_w_d     = meas_w_q;
        meas_h_d     = meas_h_q;
`endif
        case (state_q)
            SEARCH: begin
                if (vs_fall_s) state_d = VSYNC;
                else           state_d = SEARCH;
            end
            VSYNC: begin
                x_d        = '0;
                y_d        = '0;
                line_act_d = 1'b0;
                if (vs_rise_s) state_d = FRAME;
                else           state_d = VSYNC;
            end
            FRAME: begin
                if (hs_fall_s) begin
                    x_d        = '0;
                    line_act_d = 1'b0;
                    y_d        = pix_act_s ? y_inc_sat(y_q) : y_q;
`ifdef VGA_RX_STATS_EN
                    meas_w_d   = pix_act_s ? pix_x_s : meas_w_q;
`endif
                end else begin
                    x_d        = pix_x_s;
                    line_act_d = pix_act_s;
                end
                if (vs_fall_s) begin
                    state_d      = VSYNC;
                    frame_done_d = 1'b1;
`ifdef VGA_RX_STATS_EN
                    meas_h_d     = line_act_d ? y_inc_sat(y_d) : y_d;
                    locked_d     = ({1'b0, meas_w_d} == H_LIM) && ({1'b0, meas_h_d} == V_LIM);
`else
                    locked_d     = 1'b1;
`endif
                end else begin
                    state_d = FRAME;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Input registers and decoder state; syncs reset to their idle-high level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_s1_q      <= 1'b1;
            vs_s1_q      <= 1'b1;
            hs_p_q       <= 1'b1;
            vs_p_q       <= 1'b1;
            blank_s1_q   <= 1'b0;
            rgb_s1_q     <= '0;
            state_q      <= SEARCH;
            x_q          <= '0;
            y_q          <= '0;
            line_act_q   <= 1'b0;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef VGA_RX_STATS_EN
            meas_w_q     <= '0;
            meas_h_q     <= '0;
`endif
        end else begin
            hs_s1_q      <= vga_hsync;
            vs_s1_q      <= vga_vsync;
            hs_p_q       <= hs_s1_q;
            vs_p_q       <= vs_s1_q;
            blank_s1_q   <= vga_blank_n;
            rgb_s1_q     <= {vga_r, vga_g, vga_b};
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_act_q   <= line_act_d;
            frame_done_q <= frame_done_d;
            locked_q     <= locked_d;
            overflow_q   <= overflow_d;
`ifdef VGA_RX_STATS_EN
            meas_w_q     <= meas_w_d;
            meas_h_q     <= meas_h_d;
`endif
        end
    end

    vga_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pix_in_s),
        .dout  (pix_out_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign wr_valid   = ~empty_s;
    assign pop_s      = wr_valid & wr_ready;
    assign wr_x       = pix_out_s.x;
    assign wr_y       = pix_out_s.y;
    assign wr_data    = pix_out_s.rgb;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;
`ifdef VGA_RX_STATS_EN
    assign meas_w     = meas_w_q;
    assign meas_h     = meas_h_q;
`else
    assign meas_w     = '0;
    assign meas_h     = '0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx on a reduced 8x3 window with a 4-entry FIFO.
module tb_vga_rx;

    localparam int H = 8;
    localparam int V = 3;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_hsync, vga_vsync, vga_blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        wr_valid, wr_ready;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [23:0] wr_data;
    logic        frame_done, locked, overflow;
    logic [9:0]  meas_w;
    logic [8:0]  meas_h;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          fd_count = 0;
    bit          tog      = 1'b0;
    logic [42:0] exp_q[$];

    always #5 clock = ~clock;

    vga_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .frame_done(frame_done), .locked(locked), .overflow(overflow),
        .meas_w(meas_w), .meas_h(meas_h)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [23:0] pat(input int x, input int y);
        return {5'd0, 9'(y), 10'(x)};
    endfunction

    // Monitor: samples between the stimulus edge and the active edge.
    initial begin : monitor
        logic        stall_p;
        logic        fd_p;
        logic [42:0] held, e;
        stall_p = 1'b0;
        fd_p    = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                stall_p = 1'b0;
                fd_p    = 1'b0;
            end else begin
                if (stall_p && wr_valid)
                    check({wr_x, wr_y, wr_data} == held, "stall_hold", {wr_x, wr_y, wr_data}, held);
                if (wr_valid && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_write", {wr_x, wr_y, wr_data}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({wr_x, wr_y, wr_data} == e, "write_xyd", {wr_x, wr_y, wr_data}, e);
                    end
                end
                stall_p = wr_valid && !wr_ready;
                held    = {wr_x, wr_y, wr_data};
                if (frame_done) begin
                    fd_count++;
                    check(!fd_p, "frame_done_width", 64'(fd_p), 64'd0);
                end
                fd_p = frame_done;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clock);
        if (tog) wr_ready = ~wr_ready;
    endtask

    task automatic line(input int y, input int w, input int keep, input bit lat);
        for (int i = 0; i < w; i++) begin
            vga_blank_n = 1'b1;
            {vga_r, vga_g, vga_b} = pat(i, y);
            if (i < H && y < V && i < keep) exp_q.push_back({10'(i), 9'(y), pat(i, y)});
            cyc();
            if (lat && i == 0) check(wr_valid == 1'b0, "latency_early", 64'(wr_valid), 64'd0);
            if (lat && i == 1) check(wr_valid == 1'b1, "latency_2cyc", 64'(wr_valid), 64'd1);
        end
        vga_blank_n = 1'b0;
        repeat (2) cyc();
        vga_hsync = 1'b0;
        repeat (2) cyc();
        vga_hsync = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic vs_pulse();
        vga_vsync = 1'b0;
        repeat (3) cyc();
        vga_vsync = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic frame(input int nl, input int w, input int keep, input bit lat);
        for (int y = 0; y < nl; y++) line(y, w, keep, lat && (y == 0));
        vs_pulse();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wr_valid) && n < 200) begin
            cyc();
            n++;
        end
        check(exp_q.size() == 0 && !wr_valid, "drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_frame(input int fd, input int mw, input int mh, input bit lk_stats);
        check(fd_count == fd, "frame_count", 64'(fd_count), 64'(fd));
`ifdef VGA_RX_STATS_EN
        check(locked == lk_stats, "locked", 64'(locked), 64'(lk_stats));
        check(meas_w == 10'(mw), "meas_w", 64'(meas_w), 64'(mw));
        check(meas_h == 9'(mh), "meas_h", 64'(meas_h), 64'(mh));
`else
        check(locked == 1'b1, "locked", 64'(locked), 64'd1);
        check(meas_w == 10'd0, "meas_w", 64'(meas_w), 64'd0);
        check(meas_h == 9'd0, "meas_h", 64'(meas_h), 64'd0);
`endif
    endtask

    initial begin : stimulus
        reset = 1'b1;
        vga_hsync = 1'b1; vga_vsync = 1'b1; vga_blank_n = 1'b0;
        vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
        wr_ready = 1'b1;
        repeat (2) @(negedge clock);
        check(wr_valid == 1'b0, "rst_wr_valid", 64'(wr_valid), 64'd0);
        check({wr_x, wr_y, wr_data} == 43'd0, "rst_wr_fields", {wr_x, wr_y, wr_data}, 64'd0);
        check(frame_done == 1'b0, "rst_frame_done", 64'(frame_done), 64'd0);
        check(locked == 1'b0, "rst_locked", 64'(locked), 64'd0);
        check(overflow == 1'b0, "rst_overflow", 64'(overflow), 64'd0);
        check(meas_w == 10'd0 && meas_h == 9'd0, "rst_meas", {meas_w, meas_h}, 64'd0);
        reset = 1'b0;
        cyc();

        // Pixels before any vsync are ignored.
        line(0, 6, 0, 1'b0);
        repeat (3) cyc();
        check(wr_valid == 1'b0, "search_ignored", 64'(wr_valid), 64'd0);
        vs_pulse();
        check(fd_count == 0, "no_fd_on_entry", 64'(fd_count), 64'd0);

        // Frame A: exact 8x3, latency checked on the first pixel.
        frame(3, 8, 99, 1'b1);
        drain();
        check_frame(1, 8, 3, 1'b1);

        // Frame B: 5 lines of 10 pixels, columns 8-9 and rows 3-4 clipped.
        frame(5, 10, 99, 1'b0);
        drain();
        check_frame(2, 10, 5, 1'b0);

        // Frame C: ready toggling every cycle, FIFO never fills.
        tog = 1'b1;
        frame(3, 4, 99, 1'b0);
        drain();
        tog = 1'b0;
        wr_ready = 1'b1;
        check_frame(3, 4, 3, 1'b0);
        check(overflow == 1'b0, "no_overflow_yet", 64'(overflow), 64'd0);

        // Frame D: sink stalled for a 10-pixel line, only x 0-3 survive.
        wr_ready = 1'b0;
        frame(1, 10, 4, 1'b0);
        check(overflow == 1'b1, "overflow_set", 64'(overflow), 64'd1);
        wr_ready = 1'b1;
        drain();
        check_frame(4, 10, 1, 1'b0);

        // Frame E: clean frame relocks; overflow stays sticky.
        frame(3, 8, 99, 1'b0);
        drain();
        check_frame(5, 8, 3, 1'b1);
        check(overflow == 1'b1, "overflow_sticky", 64'(overflow), 64'd1);

        // Reset in the middle of a line flushes the queued pixels.
        wr_ready = 1'b0;
        vga_blank_n = 1'b1;
        {vga_r, vga_g, vga_b} = 24'h00ABCD;
        repeat (4) cyc();
        reset = 1'b1;
        exp_q.delete();
        cyc();
        check(wr_valid == 1'b0, "midrst_wr_valid", 64'(wr_valid), 64'd0);
        check(locked == 1'b0, "midrst_locked", 64'(locked), 64'd0);
        check(overflow == 1'b0, "midrst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        wr_ready = 1'b1;
        line(1, 8, 0, 1'b0);
        repeat (3) cyc();
        check(wr_valid == 1'b0, "no_write_before_vsync", 64'(wr_valid), 64'd0);
        vs_pulse();
        check(fd_count == 5, "no_fd_after_reset", 64'(fd_count), 64'd5);
        frame(3, 8, 99, 1'b0);
        drain();
        check_frame(6, 8, 3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
